// File: rtl/add_pkg.sv
// Shared constants and helpers for the add_pipe skewed-carry adder.
// Holds the op-select encodings and the signed saturation limits for any width.
package add_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int MAX_W = 1024;

    // Largest positive two's-complement value of width w, zero-extended to MAX_W.
    function automatic logic [MAX_W-1:0] sat_pos(input int w);
        return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] sat_neg(input int w);
        return MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/add_pipe_stage.sv
// One slice of the skewed adder: adds chunk IDX with the carry from the previous
// slice and forwards the operands, partial result and control one stage on.
module add_pipe_stage
    import add_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             adv_i,
    input  logic             valid_i,
    input  logic             carry_i,
    input  logic             sat_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [WIDTH-1:0] res_i,
    output logic             valid_o,
    output logic             carry_o,
    output logic             sat_o,
    output logic [WIDTH-1:0] x_o,
    output logic [WIDTH-1:0] y_o,
    output logic [WIDTH-1:0] res_o
);

    logic [CHUNK:0]   sum_w;
    logic             carry_d;
    logic [WIDTH-1:0] res_d;

    logic             valid_q;
    logic             carry_q;
    logic             sat_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] res_q;

    // NOTE: every variable written here gets a full default first so no latch is inferred.
    always_comb begin
        sum_w   = {1'b0, x_i[IDX*CHUNK +: CHUNK]}
                + {1'b0, y_i[IDX*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, carry_i};
        carry_d = sum_w[CHUNK];
        res_d   = res_i;
        res_d[IDX*CHUNK +: CHUNK] = sum_w[CHUNK-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all stages see pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            valid_q <= 1'b0;
        end else if (adv_i) begin
            valid_q <= valid_i;
        end
    end

    // NOTE: the datapath registers carry no reset; valid_q alone qualifies their contents.
    always_ff @(posedge clk) begin
        if (adv_i) begin
            carry_q <= carry_d;
            sat_q   <= sat_i;
            x_q     <= x_i;
            y_q     <= y_i;
            res_q   <= res_d;
        end
    end

    assign valid_o = valid_q;
    assign carry_o = carry_q;
    assign sat_o   = sat_q;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign res_o   = res_q;

endmodule

// File: rtl/add_pipe.sv
// Pipelined add/subtract with valid/ready flow control and a skewed carry chain.
// Optional signed saturation is compiled in with macro ADD_PIPE_SAT_EN.
module add_pipe
    import add_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;

    logic             adv;
    logic [STAGES:0]  valid_c;
    logic [STAGES:0]  carry_c;
    logic [STAGES:0]  sat_c;
    logic [WIDTH-1:0] x_c   [STAGES+1];
    logic [WIDTH-1:0] y_c   [STAGES+1];
    logic [WIDTH-1:0] res_c [STAGES+1];

    // The whole pipe moves as one; a stalled output freezes every stage, bubbles included.
    assign adv      = out_ready | ~valid_c[STAGES];
    assign in_ready = adv;

    assign valid_c[0] = in_valid;
    assign carry_c[0] = (sub == OP_ADD) ? c_in : 1'b1;
    assign sat_c[0]   = sat;
    assign x_c[0]     = x;
    assign y_c[0]     = (sub == OP_SUB) ? ~y : y;
    assign res_c[0]   = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        add_pipe_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk     (clk),
            .clr     (clr),
            .adv_i   (adv),
            .valid_i (valid_c[k]),
            .carry_i (carry_c[k]),
            .sat_i   (sat_c[k]),
            .x_i     (x_c[k]),
            .y_i     (y_c[k]),
            .res_i   (res_c[k]),
            .valid_o (valid_c[k+1]),
            .carry_o (carry_c[k+1]),
            .sat_o   (sat_c[k+1]),
            .x_o     (x_c[k+1]),
            .y_o     (y_c[k+1]),
            .res_o   (res_c[k+1])
        );
    end

    logic             x_sign;
    logic             y_sign;
    logic             ovf_w;
    logic [WIDTH-1:0] s_w;
    logic             unused_ops;

    assign x_sign     = x_c[STAGES][WIDTH-1];
    assign y_sign     = y_c[STAGES][WIDTH-1];
    assign unused_ops = ^{x_c[STAGES][WIDTH-2:0], y_c[STAGES][WIDTH-2:0]};

`ifdef ADD_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
    localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));
`else
    logic unused_sat;
    assign unused_sat = sat_c[STAGES];
`endif

    always_comb begin
        ovf_w = (x_sign == y_sign) && (res_c[STAGES][WIDTH-1] != x_sign);
        s_w   = res_c[STAGES];
`ifdef ADD_PIPE_SAT_EN
        // Both operands negative means the true result fell below the range.
        if (sat_c[STAGES] && ovf_w) begin
            s_w = x_sign ? SAT_NEG : SAT_POS;
        end
`endif
    end

    // Results are gated by out_valid so clr blanks them without waiting for a clock.
    assign out_valid = valid_c[STAGES];
    assign s         = out_valid ? s_w : '0;
    assign c_out     = out_valid & carry_c[STAGES];
    assign ovf       = out_valid & ovf_w;
    assign zero      = out_valid & (s_w == '0);

endmodule

// File: doc/add_pipe.md
ADD_PIPE -- requirements
Module: add_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width in bits (>=8).
REQ-002 SHALL provide parameter STAGES, default 4, pipeline depth; WIDTH SHALL be divisible by STAGES.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 x, y  input  WIDTH each  operands.
REQ-008 c_in  input  1  carry-in for add; ignored when sub=1.
REQ-009 sub  input  1  0 = x+y+c_in, 1 = x-y.
REQ-010 sat  input  1  signed saturation request; honoured only per REQ-028.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 s  output  WIDTH  sum/difference.
REQ-014 c_out, ovf, zero  output  1 each  carry-out, signed overflow, result==0.

Function
REQ-015 Datapath SHALL be split into STAGES chunks of WIDTH/STAGES bits; stage k SHALL add chunk k using the registered carry from stage k-1, passing upper operand bits forward and lower result bits along (skewed pipeline).
REQ-016 Subtract SHALL compute x + ~y + 1; c_out=1 means no borrow.
REQ-017 ovf SHALL be 1 iff x and effective y (y or ~y) share sign bit and s sign differs.
REQ-018 zero SHALL reflect final s, after saturation when applied.
REQ-019 Latency SHALL be exactly STAGES cycles from accepted input to out_valid with no stall; throughput one op/cycle.
REQ-020 Pipeline advance enable adv = out_ready OR NOT out_valid; in_ready SHALL equal adv (combinational).
REQ-021 Input accepted when in_valid AND in_ready; bubble enters when in_valid=0 and adv=1.
REQ-022 When adv=0 all stage registers, valids and outputs SHALL hold; no result dropped or duplicated; order preserved.
REQ-023 s, c_out, ovf, zero SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 Internal bubbles are not collapsed during a stall.

Reset
REQ-025 clr=1 SHALL immediately clear all stage valid bits, out_valid, s, c_out, ovf, zero to 0.
REQ-026 clr asserted mid-operation SHALL discard all in-flight ops; first out_valid after release arises only from operands accepted after release.
REQ-027 in_ready SHALL be 1 during and after clr (out_valid=0).

Configuration
REQ-028 Macro ADD_PIPE_SAT_EN defined: when sat=1 and ovf=1, s SHALL clamp to 0x7F..F (positive overflow) or 0x80..0 (negative); ovf still reports 1; c_out unchanged.
REQ-029 Macro undefined: sat port present but ignored; s is wrapped result; no clamp logic synthesised.

Structure
REQ-030 Shared package add_pkg SHALL hold op-select constants (OP_ADD=0, OP_SUB=1) and saturation limit functions of WIDTH.
REQ-031 One sub-module add_pipe_stage (chunk adder + registers, parameter CHUNK) SHALL be instantiated STAGES times via generate.

Verification (WIDTH=32, STAGES=4)
REQ-032 x=0xFFFFFFFF, y=0, c_in=1, add -> 4 cycles later s=0x00000000, c_out=1, zero=1, ovf=0.
REQ-033 x=0x7FFFFFFF, y=1, add, sat=1 -> s=0x80000000, ovf=1 without macro; s=0x7FFFFFFF, ovf=1 with ADD_PIPE_SAT_EN.
REQ-034 x=5, y=7, sub -> s=0xFFFFFFFE, c_out=0, ovf=0; x=7, y=5, sub -> s=2, c_out=1.
REQ-035 8 back-to-back ops (x=i, y=0x10*i), out_ready low cycles 3-5 -> in_ready low those cycles, 8 correct results in order, none lost or repeated.
REQ-036 clr pulsed with 3 ops in flight -> out_valid=0 same cycle, none of the 3 ever emitted; new op after release emerges 4 cycles later.
